line_ring_buffer: RTL and testbench

Parametrised multi-line ring buffer, successor to the single-line string buffer between the camera buffer fillers and the SDRAM frame writer. Writer fills one line and commits it; reader consumes committed lines in FIFO order and releases each when finished. Adds line-level flow control, overflow accounting, flush and registered (block-RAM) reads. Single clock domain; CDC stays outside this block.

---
 rtl/line_buf_pkg.sv | 11 +
 rtl/line_ring_buffer_if.sv | 40 ++++
 rtl/line_buf_ram.sv | 36 +++
 rtl/line_ring_buffer.sv | 116 +++++++++++
 tb/tb_line_ring_buffer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_buf_pkg.sv
// Shared constants and helpers for the multi-line ring buffer.
package line_buf_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  // Index width for a given number of lines; never below one bit.
  function automatic int unsigned idx_width(input int unsigned num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

endpackage

// File: rtl/line_ring_buffer_if.sv
// Writer/reader bus of the line ring buffer; master is the client side, slave the buffer.
interface line_ring_buffer_if
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned NUM_LINES  = 4
) ();

  localparam int unsigned IDX_W = idx_width(NUM_LINES);

  logic                  flush;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_commit;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_release;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  line_avail;
  logic [IDX_W:0]        line_count;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output flush, wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release, ovf_clr,
    input  rd_data, rd_valid, line_avail, line_count, wr_idx, rd_idx, overflow, drop_cnt
  );

  modport slave (
    input  flush, wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release, ovf_clr,
    output rd_data, rd_valid, line_avail, line_count, wr_idx, rd_idx, overflow, drop_cnt
  );

endinterface

// File: rtl/line_buf_ram.sv
// Simple dual-port RAM: synchronous write, registered read that holds when not enabled.
module line_buf_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register is reset so rd_data reads 0 out of reset; the array itself is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_ring_buffer.sv
// Multi-line ring buffer: writer commits whole lines, reader consumes and releases them in order.
module line_ring_buffer
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned LINE_LEN   = 800,
  parameter int unsigned NUM_LINES  = 4
) (
  input logic               clk,
  input logic               rst,
  line_ring_buffer_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_LINES);
  localparam logic [IDX_W:0]      MaxCount = (IDX_W+1)'(NUM_LINES - 1);
  localparam logic [ADDR_WIDTH:0] LineLen  = (ADDR_WIDTH+1)'(LINE_LEN);

  logic [IDX_W:0]        count_q, count_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  rd_valid_q, rd_valid_d;

  logic do_release, do_commit, do_drop;
  logic wr_in_range, rd_in_range;

  assign wr_in_range = ({1'b0, bus.wr_addr} < LineLen);
  assign rd_in_range = ({1'b0, bus.rd_addr} < LineLen);

  // A release in the same cycle frees a slot, so a commit at full is accepted then.
  assign do_release = bus.rd_release && (count_q != '0);
  assign do_commit  = bus.wr_commit && ((count_q != MaxCount) || do_release);
  assign do_drop    = bus.wr_commit && !bus.flush && (count_q == MaxCount) && !do_release;

  always_comb begin
    count_d    = count_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    rd_valid_d = bus.rd_en && (count_q != '0) && rd_in_range && !bus.flush;

    if (bus.flush) begin
      count_d  = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      if (do_commit) begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
      if (do_release) begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
      if (do_commit && !do_release) begin
        count_d = count_q + 1'b1;
      end else if (do_release && !do_commit) begin
        count_d = count_q - 1'b1;
      end
    end

    // Clear first so a simultaneous drop leaves the count at one.
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (do_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) begin
        drop_cnt_d = drop_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  line_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IDX_W + ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bus.wr_en && wr_in_range),
    .waddr_i ({wr_idx_q, bus.wr_addr}),
    .wdata_i (bus.wr_data),
    .re_i    (bus.rd_en),
    .raddr_i ({rd_idx_q, bus.rd_addr}),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid   = rd_valid_q;
  assign bus.line_avail = (count_q != '0);
  assign bus.line_count = count_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.rd_idx     = rd_idx_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_line_ring_buffer.sv
// Directed self-checking bench for line_ring_buffer with hand-computed expectations.
module tb_line_ring_buffer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  line_ring_buffer_if #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (11),
    .NUM_LINES  (4)
  ) bus ();

  line_ring_buffer #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (11),
    .LINE_LEN   (800),
    .NUM_LINES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.flush      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_commit  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_release = 1'b0;
    bus.ovf_clr    = 1'b0;
  endtask

  // Advance one edge; afterwards outputs reflect that edge and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cols(input int first, input int last, input logic [15:0] base);
    for (int c = first; c <= last; c++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 11'(c);
      bus.wr_data = base + 16'(c);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_commit = 1'b1;
      tick();
    end
    bus.wr_commit = 1'b0;
  endtask

  task automatic release_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rd_release = 1'b1;
      tick();
    end
    bus.rd_release = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.rd_valid, bus.line_avail, bus.overflow} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000", {bus.rd_valid, bus.line_avail, bus.overflow});
    end
    tests_run++;
    if ({bus.line_count, bus.wr_idx, bus.rd_idx} !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_idx: got count=%0d wr=%0d rd=%0d expected 0/0/0",
               bus.line_count, bus.wr_idx, bus.rd_idx);
    end
    tests_run++;
    if ({bus.rd_data, bus.drop_cnt} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got rd_data=%0h drop=%0d expected 0/0", bus.rd_data, bus.drop_cnt);
    end
  endtask

  task automatic test_write_read();
    write_cols(0, 799, 16'h0000);
    commit_n(1);
    tests_run++;
    if (bus.line_count !== 3'd1 || bus.wr_idx !== 2'd1 || bus.line_avail !== 1'b1) begin
      tests_failed++;
      $display("FAIL commit_one: got count=%0d wr=%0d avail=%b expected 1/1/1",
               bus.line_count, bus.wr_idx, bus.line_avail);
    end
    bus.rd_en   = 1'b1;
    bus.rd_addr = 11'd5;
    tick();
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'd5) begin
      tests_failed++;
      $display("FAIL read_col5: got valid=%b data=%0h expected 1/5", bus.rd_valid, bus.rd_data);
    end
    bus.rd_en   = 1'b1;
    bus.rd_addr = 11'd799;
    tick();
    tests_run++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'd799) begin
      tests_failed++;
      $display("FAIL read_col799: got valid=%b data=%0h expected 1/31f", bus.rd_valid, bus.rd_data);
    end
    bus.rd_addr = 11'd800;
    tick();
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_oob: got valid=%b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_read_release();
    write_cols(0, 9, 16'h1000);
    commit_n(1);
    bus.rd_en      = 1'b1;
    bus.rd_addr    = 11'd5;
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
    tests_run++;
    if (bus.rd_data !== 16'd5 || bus.rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_rel_data: got valid=%b data=%0h expected 1/5", bus.rd_valid, bus.rd_data);
    end
    tests_run++;
    if (bus.rd_idx !== 2'd1 || bus.line_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL rd_rel_ptr: got rd=%0d count=%0d expected 1/1", bus.rd_idx, bus.line_count);
    end
    tick();
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_data !== 16'h1005) begin
      tests_failed++;
      $display("FAIL read_line1: got %0h expected 1005", bus.rd_data);
    end
    release_n(2);
    tests_run++;
    if (bus.rd_idx !== 2'd2 || bus.line_count !== 3'd0 || bus.line_avail !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_empty: got rd=%0d count=%0d avail=%b expected 2/0/0",
               bus.rd_idx, bus.line_count, bus.line_avail);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_empty: got valid=%b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    commit_n(3);
    tests_run++;
    if (bus.line_count !== 3'd3 || bus.wr_idx !== 2'd3 || bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill: got count=%0d wr=%0d ovf=%b expected 3/3/0",
               bus.line_count, bus.wr_idx, bus.overflow);
    end
    commit_n(1);
    tests_run++;
    if (bus.line_count !== 3'd3 || bus.wr_idx !== 2'd3 || bus.overflow !== 1'b1 ||
        bus.drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL drop_one: got count=%0d wr=%0d ovf=%b drop=%0d expected 3/3/1/1",
               bus.line_count, bus.wr_idx, bus.overflow, bus.drop_cnt);
    end
  endtask

  task automatic test_commit_release_full();
    bus.wr_commit  = 1'b1;
    bus.rd_release = 1'b1;
    tick();
    bus.wr_commit  = 1'b0;
    bus.rd_release = 1'b0;
    tests_run++;
    if (bus.line_count !== 3'd3 || bus.wr_idx !== 2'd0 || bus.rd_idx !== 2'd1 ||
        bus.drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL commit_release: got count=%0d wr=%0d rd=%0d drop=%0d expected 3/0/1/1",
               bus.line_count, bus.wr_idx, bus.rd_idx, bus.drop_cnt);
    end
  endtask

  task automatic test_drop_saturate();
    commit_n(300);
    tests_run++;
    if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1 || bus.wr_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL drop_sat: got drop=%0d ovf=%b wr=%0d expected 255/1/0",
               bus.drop_cnt, bus.overflow, bus.wr_idx);
    end
    bus.ovf_clr = 1'b1;
    tick();
    tests_run++;
    if (bus.drop_cnt !== 8'd0 || bus.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clr: got drop=%0d ovf=%b expected 0/0", bus.drop_cnt, bus.overflow);
    end
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
    bus.ovf_clr   = 1'b0;
    tests_run++;
    if (bus.drop_cnt !== 8'd1 || bus.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_vs_drop: got drop=%0d ovf=%b expected 1/1", bus.drop_cnt, bus.overflow);
    end
  endtask

  task automatic test_flush();
    do_reset();
    commit_n(4);
    release_n(1);
    // count=2, wr=3, rd=1, one drop recorded; flush also carries commit, release and a pixel.
    bus.flush      = 1'b1;
    bus.wr_commit  = 1'b1;
    bus.rd_release = 1'b1;
    bus.rd_en      = 1'b1;
    bus.rd_addr    = 11'd0;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 11'd7;
    bus.wr_data    = 16'hbeef;
    tick();
    clear_inputs();
    tests_run++;
    if (bus.line_count !== 3'd0 || bus.wr_idx !== 2'd0 || bus.rd_idx !== 2'd0 ||
        bus.line_avail !== 1'b0 || bus.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_state: got count=%0d wr=%0d rd=%0d avail=%b valid=%b expected 0/0/0/0/0",
               bus.line_count, bus.wr_idx, bus.rd_idx, bus.line_avail, bus.rd_valid);
    end
    tests_run++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL flush_keep_ovf: got ovf=%b drop=%0d expected 1/1", bus.overflow, bus.drop_cnt);
    end
    commit_n(3);
    release_n(3);
    commit_n(1);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 11'd7;
    tick();
    tests_run++;
    if (bus.rd_idx !== 2'd3 || bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hbeef) begin
      tests_failed++;
      $display("FAIL flush_write: got rd=%0d valid=%b data=%0h expected 3/1/beef",
               bus.rd_idx, bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_async_reset();
    // rd_en still high from the previous read; assert reset between edges.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 11'd3;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.rd_valid, bus.line_avail, bus.overflow, bus.line_count, bus.wr_idx, bus.rd_idx,
         bus.drop_cnt, bus.rd_data} !== 34'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b cnt=%0d wr=%0d rd=%0d ovf=%b drop=%0d data=%0h expected all 0",
               bus.rd_valid, bus.line_count, bus.wr_idx, bus.rd_idx, bus.overflow,
               bus.drop_cnt, bus.rd_data);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    clear_inputs();
    test_reset();
    test_write_read();
    test_read_release();
    test_overflow();
    test_commit_release_full();
    test_drop_saturate();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
